// File: rtl/veda_cmd_seq.sv
// veda_cmd_seq: FIFO-buffered command sequencer driving the mod_veda register file.
// Define VEDA_SEQ_WR_ACK_EN to make writes return a response carrying the written data.
module veda_cmd_seq #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_mode,
    input  logic [ADDR_W-1:0]        cmd_addr_a,
    input  logic [ADDR_W-1:0]        cmd_addr_b,
    input  logic [DATA_W-1:0]        cmd_data,
    output logic                     rf_write_enable,
    output logic                     rf_mode,
    output logic [ADDR_W-1:0]        rf_addr_a,
    output logic [ADDR_W-1:0]        rf_addr_b,
    output logic [DATA_W-1:0]        rf_datain,
    input  logic [DATA_W-1:0]        rf_dataout,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_W-1:0]        rsp_data,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   cmd_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 1 + 2 * ADDR_W + DATA_W;
    localparam int CW = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state, state_d;
    logic [EW-1:0]   mem [DEPTH];
    logic [EW-1:0]   head;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   lat_cnt;
    logic            push, pop, sample, wr_ack;

    assign head      = mem[rd_ptr];
    assign cmd_ready = cmd_count != (AW + 1)'(DEPTH);
    assign push      = cmd_valid && cmd_ready;
    assign busy      = (state != IDLE) || (cmd_count != '0);

    always_comb begin
        state_d = state;
        pop     = 1'b0;
        sample  = 1'b0;
        wr_ack  = 1'b0;
        case (state)
            IDLE: begin
                pop     = cmd_count != '0;
                state_d = pop ? ISSUE : IDLE;
            end
            ISSUE: begin
                if (rf_mode) begin
                    sample  = RD_LAT == 1;
                    state_d = (RD_LAT == 1) ? RESP : WAIT;
                end else begin
`ifdef VEDA_SEQ_WR_ACK_EN
                    wr_ack  = 1'b1;
                    state_d = RESP;
`else
                    state_d = IDLE;
`endif
                end
            end
            WAIT: begin
                // counter holds cycles left including this one; the last one samples
                sample  = lat_cnt == CW'(1);
                state_d = sample ? RESP : WAIT;
            end
            RESP:    state_d = rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {cmd_mode, cmd_addr_a, cmd_addr_b, cmd_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            cmd_count       <= '0;
            lat_cnt         <= '0;
            rf_write_enable <= 1'b0;
            rf_mode         <= 1'b0;
            rf_addr_a       <= '0;
            rf_addr_b       <= '0;
            rf_datain       <= '0;
            rsp_valid       <= 1'b0;
            rsp_data        <= '0;
        end else begin
            state           <= state_d;
            wr_ptr          <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr          <= pop ? rd_ptr + AW'(1) : rd_ptr;
            cmd_count       <= cmd_count + (AW + 1)'(push) - (AW + 1)'(pop);
            lat_cnt         <= (state == ISSUE) ? CW'(RD_LAT - 1) : (state == WAIT) ? lat_cnt - CW'(1) : lat_cnt;
            rf_write_enable <= pop && !head[EW-1];
            if (pop) {rf_mode, rf_addr_a, rf_addr_b, rf_datain} <= head;
            rsp_valid       <= state_d == RESP;
            rsp_data        <= sample ? rf_dataout : wr_ack ? rf_datain : rsp_data;
        end
    end
endmodule

// File: tb/tb_veda_cmd_seq.sv
// tb_veda_cmd_seq: directed bench with a RD_LAT=1 sequencer on a register-file model
// and a RD_LAT=3 sequencer on a hand-driven rf_dataout.
module tb_veda_cmd_seq;
`ifdef VEDA_SEQ_WR_ACK_EN
    localparam bit ACK = 1'b1;
`else
    localparam bit ACK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  cv = '0;
    logic [1:0]  rr = '0;
    logic        cmd_mode = 1'b0;
    logic [4:0]  cmd_addr_a = '0, cmd_addr_b = '0;
    logic [31:0] cmd_data = '0;
    logic        rdy0, we0, mode0, rv0, busy0;
    logic [4:0]  aa0, ab0;
    logic [31:0] din0, dout0, rd0;
    logic [2:0]  cnt0;
    logic        rdy3, we3, mode3, rv3, busy3;
    logic [4:0]  aa3, ab3;
    logic [31:0] din3, rd3;
    logic [31:0] dout3 = 32'hDEAD;
    logic [2:0]  cnt3;
    logic [31:0] regs [32] = '{default: 32'd0};
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    veda_cmd_seq #(.DEPTH(4), .ADDR_W(5), .DATA_W(32), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cv[0]), .cmd_ready(rdy0), .cmd_mode(cmd_mode),
        .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b), .cmd_data(cmd_data),
        .rf_write_enable(we0), .rf_mode(mode0), .rf_addr_a(aa0), .rf_addr_b(ab0),
        .rf_datain(din0), .rf_dataout(dout0), .rsp_valid(rv0), .rsp_ready(rr[0]),
        .rsp_data(rd0), .busy(busy0), .cmd_count(cnt0)
    );

    veda_cmd_seq #(.DEPTH(4), .ADDR_W(5), .DATA_W(32), .RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .cmd_valid(cv[1]), .cmd_ready(rdy3), .cmd_mode(cmd_mode),
        .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b), .cmd_data(cmd_data),
        .rf_write_enable(we3), .rf_mode(mode3), .rf_addr_a(aa3), .rf_addr_b(ab3),
        .rf_datain(din3), .rf_dataout(dout3), .rsp_valid(rv3), .rsp_ready(rr[1]),
        .rsp_data(rd3), .busy(busy3), .cmd_count(cnt3)
    );

    // register-file model: write to addr_a, combinational read of addr_b
    always @(posedge clk) if (we0) regs[aa0] <= din0;
    assign dout0 = regs[ab0];

    typedef struct {
        logic        mode;
        logic [4:0]  a;
        logic [4:0]  b;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int s, input logic m, input logic [4:0] a, input logic [4:0] b, input logic [31:0] d);
        cmd_mode = m; cmd_addr_a = a; cmd_addr_b = b; cmd_data = d;
        chk("push ready", s == 0 ? rdy0 : rdy3, 1);
        cv[s] = 1'b1;
        @(negedge clk);
        cv[s] = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        bit resp;
        resp = v.mode || ACK;
        push(0, v.mode, v.a, v.b, v.d);
        @(negedge clk);
        chk("issue we", we0, !v.mode);
        chk("issue mode", mode0, v.mode);
        chk("issue addr_a", aa0, v.a);
        chk("issue addr_b", ab0, v.b);
        if (!v.mode) chk("issue datain", din0, v.d);
        chk("issue no rsp", rv0, 0);
        chk("issue busy", busy0, 1);
        @(negedge clk);
        chk("we one cycle", we0, 0);
        chk("rsp valid", rv0, resp);
        if (resp) begin
            chk("rsp data", rd0, v.exp);
            @(negedge clk);
            chk("rsp hold valid", rv0, 1);
            chk("rsp hold data", rd0, v.exp);
            rr[0] = 1'b1;
            @(negedge clk);
            rr[0] = 1'b0;
            chk("rsp cleared", rv0, 0);
        end
        @(negedge clk);
        chk("idle busy", busy0, 0);
    endtask

    initial begin
        int wi, ri, nr, bad;
        logic [31:0] exp_rsp [5];
        logic [4:0]  exp_wa  [2];
        logic [31:0] exp_wd  [2];

        vecs[0] = '{1'b0, 5'd12, 5'd10, 32'd55,         32'd55};
        vecs[1] = '{1'b1, 5'd2,  5'd12, 32'd0,          32'd55};
        vecs[2] = '{1'b0, 5'd3,  5'd0,  32'hA5A5_0001,  32'hA5A5_0001};
        vecs[3] = '{1'b1, 5'd0,  5'd3,  32'd0,          32'hA5A5_0001};
        vecs[4] = '{1'b0, 5'd31, 5'd0,  32'hFFFF_FFFF,  32'hFFFF_FFFF};
        vecs[5] = '{1'b1, 5'd31, 5'd31, 32'd0,          32'hFFFF_FFFF};
        vecs[6] = '{1'b1, 5'd0,  5'd7,  32'd0,          32'd0};
        vecs[7] = '{1'b0, 5'd12, 5'd0,  32'd56,         32'd56};
        vecs[8] = '{1'b1, 5'd1,  5'd12, 32'd0,          32'd56};

        repeat (2) @(negedge clk);
        chk("rst we", we0, 0);
        chk("rst rsp_valid", rv0, 0);
        chk("rst rsp_data", rd0, 0);
        chk("rst count", cnt0, 0);
        chk("rst busy", busy0, 0);
        chk("rst addr_a", aa0, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready after rst", rdy0, 1);

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // fill the FIFO behind a stalled read response
        exp_wa = '{5'd5, 5'd6};
        exp_wd = '{32'd77, 32'd88};
        if (ACK) begin
            exp_rsp = '{32'd56, 32'd77, 32'd77, 32'd88, 32'd88};
            nr = 5;
        end else begin
            exp_rsp = '{32'd56, 32'd77, 32'd88, 32'd0, 32'd0};
            nr = 3;
        end
        cmd_mode = 1'b1; cmd_addr_a = 5'd0; cmd_addr_b = 5'd12; cmd_data = 32'd0;
        chk("fill ready 0", rdy0, 1); cv[0] = 1'b1; @(negedge clk);
        cmd_mode = 1'b0; cmd_addr_a = 5'd5; cmd_data = 32'd77;
        chk("fill ready 1", rdy0, 1); @(negedge clk);
        cmd_mode = 1'b1; cmd_addr_b = 5'd5;
        chk("fill ready 2", rdy0, 1); @(negedge clk);
        cmd_mode = 1'b0; cmd_addr_a = 5'd6; cmd_data = 32'd88;
        chk("fill ready 3", rdy0, 1); @(negedge clk);
        cmd_mode = 1'b1; cmd_addr_b = 5'd6;
        chk("fill ready 4", rdy0, 1); @(negedge clk);
        cv[0] = 1'b0;
        chk("full count", cnt0, 4);
        chk("full not ready", rdy0, 0);
        chk("full rsp valid", rv0, 1);
        wi = 0; ri = 0;
        for (int c = 0; c < 60; c++) begin
            if (we0) begin
                if (wi < 2) begin
                    chk("order wr addr", aa0, exp_wa[wi]);
                    chk("order wr data", din0, exp_wd[wi]);
                end
                wi++;
            end
            if (rr[0]) rr[0] = 1'b0;
            else if (rv0) begin
                if (ri < nr) chk("order rsp data", rd0, exp_rsp[ri]);
                ri++;
                rr[0] = 1'b1;
            end
            if (wi >= 2 && ri >= nr && !busy0 && !rr[0]) break;
            @(negedge clk);
        end
        chk("fill writes seen", wi, 2);
        chk("fill rsps seen", ri, nr);
        chk("fill drained", busy0, 0);

        // RD_LAT=3: only the value present 3 edges after ISSUE entry is captured
        push(1, 1'b1, 5'd4, 5'd4, 32'd0);
        @(negedge clk);
        chk("lat3 issue mode", mode3, 1);
        chk("lat3 rsp 1", rv3, 0);
        @(negedge clk);
        chk("lat3 rsp 2", rv3, 0);
        @(negedge clk);
        chk("lat3 rsp 3", rv3, 0);
        dout3 = 32'hBEEF;
        @(negedge clk);
        dout3 = 32'hDEAD;
        chk("lat3 rsp valid", rv3, 1);
        chk("lat3 rsp data", rd3, 32'hBEEF);
        @(negedge clk);
        chk("lat3 rsp hold", rd3, 32'hBEEF);
        rr[1] = 1'b1;
        @(negedge clk);
        rr[1] = 1'b0;
        chk("lat3 rsp cleared", rv3, 0);

        // reset while a read waits with two commands queued behind it
        push(1, 1'b1, 5'd1, 5'd1, 32'd0);
        cmd_mode = 1'b0; cmd_addr_a = 5'd9; cmd_data = 32'h99; cv[1] = 1'b1;
        @(negedge clk);
        cmd_addr_a = 5'd10; cmd_data = 32'hAA;
        @(negedge clk);
        cv[1] = 1'b0;
        chk("pre-rst count", cnt3, 2);
        chk("pre-rst busy", busy3, 1);
        rst = 1'b1;
        #1;
        chk("async rst we", we3, 0);
        chk("async rst mode", mode3, 0);
        chk("async rst addr_a", aa3, 0);
        chk("async rst addr_b", ab3, 0);
        chk("async rst rsp_valid", rv3, 0);
        chk("async rst rsp_data", rd3, 0);
        chk("async rst count", cnt3, 0);
        chk("async rst busy", busy3, 0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (we3 || rv3 || busy3) bad++;
        end
        chk("no issue after rst", bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
